xor_arb_ctrl: RTL and testbench

Round-robin controller that shares one registered 2-bit XOR unit between `NREQ` requesters. It grants one requester at a time and latches that requester's operand pair into the shared unit. It then holds the unit busy for `LAT` cycles and returns the result with the requester's ID. It sits between the operand-producing clients and the single XOR datapath, and is the only block allowed to drive the unit's inputs.

---
 rtl/xor_arb_pkg.sv | 16 +
 rtl/xor_arb_ctrl_xor_unit.sv | 42 ++++
 rtl/xor_arb_ctrl.sv | 153 +++++++++++++++
 tb/tb_xor_arb_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_arb_pkg.sv
// Shared types and constants for the round-robin XOR arbiter controller.
package xor_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int STATS_W = 16;

  // Requester ID width; never narrower than one bit.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xor_arb_ctrl_xor_unit.sv
// Shared 2-bit XOR datapath: operand pair and owner ID captured on load,
// XOR of the captured pair presented combinationally.
module xor_unit
  import xor_arb_pkg::*;
#(
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [1:0]     opnd_in,
  input  logic [IDW-1:0] id_in,
  output logic           xor_out,
  output logic [IDW-1:0] id_out
);

  logic [1:0]     opnd_q, opnd_d;
  logic [IDW-1:0] id_q, id_d;

  always_comb begin
    opnd_d = opnd_q;
    id_d   = id_q;
    if (load) begin
      opnd_d = opnd_in;
      id_d   = id_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_q <= '0;
      id_q   <= '0;
    end else begin
      opnd_q <= opnd_d;
      id_q   <= id_d;
    end
  end

  assign xor_out = opnd_q[1] ^ opnd_q[0];
  assign id_out  = id_q;

endmodule

// File: rtl/xor_arb_ctrl.sv
// Round-robin controller sharing one registered XOR unit among NREQ clients.
// Optional ops_done statistics counter when XOR_ARB_CTRL_STATS_EN is defined.
module xor_arb_ctrl
  import xor_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int LAT  = 1,
  localparam int IDW  = idw_f(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] opnd,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  output logic              out_bit,
  output logic [IDW-1:0]    out_id
`ifdef XOR_ARB_CTRL_STATS_EN
  ,
  output logic [STATS_W-1:0] ops_done
`endif
);

  localparam int CNTW = $clog2(LAT + 1);

  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;
  logic [IDW-1:0]  out_id_q, out_id_d;

  logic            found;
  logic [IDW-1:0]  sel_id, cand;
  logic [1:0]      opnd_sel;
  logic            load;
  logic            unit_bit;
  logic [IDW-1:0]  unit_id;

  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    cand   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        sel_id = cand;
      end
    end
  end

  assign opnd_sel = opnd[{sel_id, 1'b0} +: 2];

  xor_unit #(.IDW(IDW)) u_xor_unit (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .opnd_in (opnd_sel),
    .id_in   (sel_id),
    .xor_out (unit_bit),
    .id_out  (unit_id)
  );

  // cnt counts the busy cycles still left after the grant cycle, so the
  // strobe lands LAT cycles after the grant. LAT=1 needs no busy cycle:
  // the result is registered straight from the granted operand.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    out_id_d    = out_id_q;
    gnt         = '0;
    load        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !rst) begin
          gnt[sel_id] = 1'b1;
          load        = 1'b1;
          ptr_d       = (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + IDW'(1);
          if (LAT == 1) begin
            out_valid_d = 1'b1;
            out_bit_d   = opnd_sel[1] ^ opnd_sel[0];
            out_id_d    = sel_id;
          end else begin
            cnt_d   = CNTW'(LAT - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == CNTW'(1)) begin
          out_valid_d = 1'b1;
          out_bit_d   = unit_bit;
          out_id_d    = unit_id;
          cnt_d       = '0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_id    = out_id_q;

`ifdef XOR_ARB_CTRL_STATS_EN
  logic [STATS_W-1:0] ops_done_q, ops_done_d;

  always_comb begin
    ops_done_d = ops_done_q;
    if (out_valid_q && (ops_done_q != {STATS_W{1'b1}})) begin
      ops_done_d = ops_done_q + STATS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done_q <= '0;
    end else begin
      ops_done_q <= ops_done_d;
    end
  end

  assign ops_done = ops_done_q;
`else
  // No statistics counter in this build.
`endif

endmodule

// File: tb/tb_xor_arb_ctrl.sv
// Self-checking bench for xor_arb_ctrl: instance 0 uses LAT=1, instance 1 LAT=3.
module tb_xor_arb_ctrl;

  localparam int NREQ = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a  [2];
  logic [7:0] opnd_a [2];
  logic [3:0] gnt_a  [2];
  logic       ov_a   [2];
  logic       ob_a   [2];
  logic [1:0] oid_a  [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: absolute cycle bookkeeping per instance.
  int   m_ptr    [2];
  int   m_free   [2];
  int   m_strobe [2];
  logic m_pbit   [2];
  logic m_hbit   [2];
  int   m_pid    [2];
  int   m_hid    [2];

`ifdef XOR_ARB_CTRL_STATS_EN
  logic [15:0] ops_done0, ops_done1;
  int m_ops = 0;
`endif

  always #5 clk = ~clk;

  xor_arb_ctrl #(.NREQ(4), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req_a[0]), .opnd(opnd_a[0]),
    .gnt(gnt_a[0]), .out_valid(ov_a[0]), .out_bit(ob_a[0]), .out_id(oid_a[0])
`ifdef XOR_ARB_CTRL_STATS_EN
    , .ops_done(ops_done0)
`endif
  );

  xor_arb_ctrl #(.NREQ(4), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req(req_a[1]), .opnd(opnd_a[1]),
    .gnt(gnt_a[1]), .out_valid(ov_a[1]), .out_bit(ob_a[1]), .out_id(oid_a[1])
`ifdef XOR_ARB_CTRL_STATS_EN
    , .ops_done(ops_done1)
`endif
  );

  function automatic int lat_of(int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int exp_idx(int m);
    if (rst || cyc < m_free[m]) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_a[m][(m_ptr[m] + k) % NREQ]) return (m_ptr[m] + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt(int m);
    int i;
    i = exp_idx(m);
    return (i < 0) ? 4'b0000 : 4'(1 << i);
  endfunction

  // Advance model and DUT by one clock edge.
  task automatic tick();
    int  idx;
    bool_dummy: begin end
`ifdef XOR_ARB_CTRL_STATS_EN
    if (rst) m_ops = 0;
    else if (cyc == m_strobe[0] && m_ops != 65535) m_ops++;
`endif
    for (int m = 0; m < 2; m++) begin
      idx = exp_idx(m);
      if (rst) begin
        m_ptr[m] = 0; m_free[m] = cyc + 1; m_strobe[m] = -1;
        m_hbit[m] = 1'b0; m_hid[m] = 0;
      end else if (idx >= 0) begin
        m_pbit[m]   = opnd_a[m][2*idx] ^ opnd_a[m][2*idx+1];
        m_pid[m]    = idx;
        m_strobe[m] = cyc + lat_of(m);
        m_free[m]   = cyc + lat_of(m);
        m_ptr[m]    = (idx + 1) % NREQ;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (cyc == m_strobe[m]) begin
        m_hbit[m] = m_pbit[m];
        m_hid[m]  = m_pid[m];
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_a[0] = '0; req_a[1] = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_a[0] = 4'b1111; req_a[1] = 4'b1111;
      opnd_a[0] = 8'($urandom); opnd_a[1] = 8'($urandom);
      #2;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (gnt_a[m] !== 4'b0000) begin
          n_err++; $display("FAIL reset_gnt[%0d] got %b want 0000", m, gnt_a[m]);
        end
        if (i > 0) begin
          n_vec++;
          if (ov_a[m] !== 1'b0 || ob_a[m] !== 1'b0 || oid_a[m] !== 2'd0) begin
            n_err++;
            $display("FAIL reset_out[%0d] got v=%b b=%b id=%0d want 0/0/0",
                     m, ov_a[m], ob_a[m], oid_a[m]);
          end
        end
      end
      tick();
    end
    rst = 1'b0;
    req_a[0] = '0; req_a[1] = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_a[0] = 4'b0001; opnd_a[0] = 8'b1010_1001;
    #2;
    n_vec++;
    if (gnt_a[0] !== 4'b0001) begin
      n_err++; $display("FAIL single_gnt got %b want 0001", gnt_a[0]);
    end
    tick();
    req_a[0] = 4'b0000;
    #2;
    n_vec++;
    if (ov_a[0] !== 1'b1 || ob_a[0] !== 1'b1 || oid_a[0] !== 2'd0) begin
      n_err++;
      $display("FAIL single_out got v=%b b=%b id=%0d want 1/1/0", ov_a[0], ob_a[0], oid_a[0]);
    end
    tick();
  endtask

  task automatic test_rotation();
    logic [7:0] op;
    do_reset();
    op = 8'($urandom);
    req_a[0] = 4'b1111; opnd_a[0] = op;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (k < 5) begin
        n_vec++;
        if (gnt_a[0] !== 4'(1 << (k % 4))) begin
          n_err++; $display("FAIL rot_gnt step %0d got %b want %b", k, gnt_a[0], 4'(1 << (k % 4)));
        end
      end
      if (k > 0) begin
        n_vec++;
        if (ov_a[0] !== 1'b1 || oid_a[0] !== 2'((k - 1) % 4) ||
            ob_a[0] !== (op[2*((k-1)%4)] ^ op[2*((k-1)%4)+1])) begin
          n_err++;
          $display("FAIL rot_out step %0d got v=%b id=%0d b=%b want 1/%0d/%b", k, ov_a[0],
                   oid_a[0], ob_a[0], (k - 1) % 4, op[2*((k-1)%4)] ^ op[2*((k-1)%4)+1]);
        end
      end
      tick();
    end
    req_a[0] = '0;
    tick();
  endtask

  task automatic test_busy_hold();
    logic [3:0] eg [7];
    eg = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    do_reset();
    opnd_a[1] = 8'b00_10_00_11;
    req_a[1]  = 4'b0101;
    for (int j = 0; j < 7; j++) begin
      #2;
      n_vec++;
      if (gnt_a[1] !== eg[j]) begin
        n_err++; $display("FAIL busy_gnt t+%0d got %b want %b", j, gnt_a[1], eg[j]);
      end
      n_vec++;
      if (ov_a[1] !== (j == 3 || j == 6)) begin
        n_err++; $display("FAIL busy_valid t+%0d got %b want %b", j, ov_a[1], (j == 3 || j == 6));
      end
      if (j == 3 || j == 6) begin
        n_vec++;
        if (ob_a[1] !== (j == 6) || oid_a[1] !== ((j == 6) ? 2'd2 : 2'd0)) begin
          n_err++;
          $display("FAIL busy_out t+%0d got b=%b id=%0d want %b/%0d", j, ob_a[1], oid_a[1],
                   (j == 6), (j == 6) ? 2 : 0);
        end
      end
      tick();
      if (j == 0) req_a[1] = 4'b0100;
      if (j == 3) req_a[1] = 4'b0000;
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    opnd_a[1] = 8'($urandom);
    req_a[1]  = 4'b0100;
    #2;
    n_vec++;
    if (gnt_a[1] !== 4'b0100) begin
      n_err++; $display("FAIL midop_gnt got %b want 0100", gnt_a[1]);
    end
    tick();
    req_a[1] = 4'b0000;
    rst = 1'b1;
    for (int j = 1; j < 6; j++) begin
      if (j == 5) req_a[1] = 4'b1111;
      #2;
      n_vec++;
      if (ov_a[1] !== 1'b0) begin
        n_err++; $display("FAIL midop_valid t+%0d got %b want 0", j, ov_a[1]);
      end
      if (j == 5) begin
        n_vec++;
        if (gnt_a[1] !== 4'b0001) begin
          n_err++; $display("FAIL midop_regrant got %b want 0001", gnt_a[1]);
        end
      end
      tick();
      rst = 1'b0;
    end
    req_a[1] = 4'b0000;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int m = 0; m < 2; m++) begin
        req_a[m]  = 4'($urandom);
        opnd_a[m] = 8'($urandom);
      end
      #2;
      for (int m = 0; m < 2; m++) begin
        n_vec++;
        if (gnt_a[m] !== exp_gnt(m)) begin
          n_err++; $display("FAIL rand_gnt[%0d] cyc %0d got %b want %b", m, cyc, gnt_a[m], exp_gnt(m));
        end
        n_vec++;
        if (ov_a[m] !== (cyc == m_strobe[m])) begin
          n_err++; $display("FAIL rand_valid[%0d] cyc %0d got %b want %b", m, cyc, ov_a[m], (cyc == m_strobe[m]));
        end
        n_vec++;
        if (ob_a[m] !== m_hbit[m] || oid_a[m] !== 2'(m_hid[m])) begin
          n_err++;
          $display("FAIL rand_out[%0d] cyc %0d got b=%b id=%0d want %b/%0d", m, cyc, ob_a[m],
                   oid_a[m], m_hbit[m], m_hid[m]);
        end
      end
`ifdef XOR_ARB_CTRL_STATS_EN
      n_vec++;
      if (ops_done0 !== 16'(m_ops)) begin
        n_err++; $display("FAIL rand_ops cyc %0d got %0d want %0d", cyc, ops_done0, m_ops);
      end
`endif
      tick();
    end
    rst = 1'b0;
    req_a[0] = '0; req_a[1] = '0;
  endtask

`ifdef XOR_ARB_CTRL_STATS_EN
  task automatic test_stats();
    do_reset();
    req_a[0] = 4'b0001; opnd_a[0] = 8'($urandom);
    for (int i = 0; i < 5; i++) tick();
    req_a[0] = 4'b0000;
    tick();
    #2;
    n_vec++;
    if (ops_done0 !== 16'd5) begin
      n_err++; $display("FAIL stats_count got %0d want 5", ops_done0);
    end
    u_dut1.ops_done_q = 16'hFFFF;
    m_ops = 65535;
    req_a[0] = 4'b0001;
    tick();
    req_a[0] = 4'b0000;
    tick();
    tick();
    #2;
    n_vec++;
    if (ops_done0 !== 16'hFFFF) begin
      n_err++; $display("FAIL stats_sat got %h want ffff", ops_done0);
    end
  endtask
`endif

  initial begin
    req_a[0] = '0; req_a[1] = '0;
    opnd_a[0] = '0; opnd_a[1] = '0;
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_free[m] = 0; m_strobe[m] = -1;
      m_pbit[m] = 1'b0; m_hbit[m] = 1'b0; m_pid[m] = 0; m_hid[m] = 0;
    end
    test_reset();
    test_single();
    test_rotation();
    test_busy_hold();
    test_midop_reset();
    test_random();
`ifdef XOR_ARB_CTRL_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
